// File: rtl/triangle_wave_checker_if.sv
// Sample stream carrying the triangle pattern into the checker.
// The pattern source drives it; the checker only listens.
interface triangle_wave_checker_if #(
   parameter int DATA_WIDTH = 12
);
   logic                  sample_valid;
   logic [DATA_WIDTH-1:0] sample;

   modport master (
      output sample_valid,
      output sample
   );

   modport slave (
      input sample_valid,
      input sample
   );
endinterface

// File: rtl/triangle_wave_checker.sv
// Locks onto a 12-bit up/down ramp, reports turnarounds and period,
// and flags and counts every sample that breaks the ramp.
module triangle_wave_checker #(
   parameter int DATA_WIDTH    = 12,
   parameter int PERIOD_WIDTH  = 16,
   parameter int ERR_CNT_WIDTH = 16
) (
   input  logic                     ref_clk,
   input  logic                     rstn,
   triangle_wave_checker_if.slave   stream,
   output logic                     locked,
   output logic                     direction,
   output logic                     peak_pulse,
   output logic                     trough_pulse,
   output logic [PERIOD_WIDTH-1:0]  period,
   output logic                     period_valid,
   output logic                     error_pulse,
   output logic [ERR_CNT_WIDTH-1:0] error_count
);

   typedef enum logic [1:0] {
      IDLE,
      ACQUIRE,
      TRACK_UP,
      TRACK_DOWN
   } state_t;

   localparam logic [DATA_WIDTH-1:0]    MAX   = '1;
   localparam logic [DATA_WIDTH:0]      ONE_D = 1;
   localparam logic [PERIOD_WIDTH-1:0]  ONE_P = 1;
   localparam logic [ERR_CNT_WIDTH-1:0] ONE_E = 1;

   state_t                   state_q, state_d;
   logic [DATA_WIDTH-1:0]    prev_q, prev_d;
   logic [PERIOD_WIDTH-1:0]  cnt_q, cnt_d, cnt_inc;
   logic                     seen_q, seen_d;
   logic                     locked_d, dir_d;
   logic                     peak_d, trough_d, pv_d, err_d;
   logic [PERIOD_WIDTH-1:0]  period_d;
   logic [ERR_CNT_WIDTH-1:0] ecnt_d;

   logic [DATA_WIDTH:0] samp_x, prev_p1, prev_m1;
   logic                step_up, step_dn;
   logic                at_max, at_zero;

   // One extra bit keeps MAX+1 and 0-1 from aliasing onto valid samples
   assign samp_x  = {1'b0, stream.sample};
   assign prev_p1 = {1'b0, prev_q} + ONE_D;
   assign prev_m1 = {1'b0, prev_q} - ONE_D;
   assign step_up = (samp_x == prev_p1);
   assign step_dn = (samp_x == prev_m1);
   assign at_max  = (prev_q == MAX);
   assign at_zero = (prev_q == '0);

   // Saturating increment, shared by the counter and the period result
   assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + ONE_P;

   always_comb begin
      state_d  = state_q;
      prev_d   = prev_q;
      cnt_d    = cnt_q;
      seen_d   = seen_q;
      locked_d = locked;
      period_d = period;
      ecnt_d   = error_count;
      peak_d   = 1'b0;
      trough_d = 1'b0;
      pv_d     = 1'b0;
      err_d    = 1'b0;

      if (stream.sample_valid) begin
         prev_d = stream.sample;
         unique case (state_q)
            IDLE: begin
               state_d = ACQUIRE;
            end
            ACQUIRE: begin
               if (step_up) begin
                  state_d  = TRACK_UP;
                  trough_d = at_zero;
               end else if (step_dn) begin
                  state_d = TRACK_DOWN;
                  peak_d  = at_max;
               end
            end
            TRACK_UP: begin
               if (step_up) begin
                  cnt_d = cnt_inc;
               end else if (at_max && step_dn) begin
                  peak_d  = 1'b1;
                  cnt_d   = cnt_inc;
                  state_d = TRACK_DOWN;
               end else begin
                  err_d = 1'b1;
               end
            end
            TRACK_DOWN: begin
               if (step_dn) begin
                  cnt_d = cnt_inc;
               end else if (at_zero && step_up) begin
                  trough_d = 1'b1;
                  cnt_d    = '0;
                  seen_d   = 1'b1;
                  state_d  = TRACK_UP;
                  if (seen_q) begin
                     period_d = cnt_inc;
                     pv_d     = 1'b1;
                     locked_d = 1'b1;
                  end
               end else begin
                  err_d = 1'b1;
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase

         if (err_d) begin
            state_d  = ACQUIRE;
            locked_d = 1'b0;
            seen_d   = 1'b0;
            if (error_count != '1) begin
               ecnt_d = error_count + ONE_E;
            end
         end
      end

      dir_d = direction;
      if (state_d == TRACK_UP) begin
         dir_d = 1'b1;
      end else if (state_d == TRACK_DOWN) begin
         dir_d = 1'b0;
      end
   end

   always_ff @(posedge ref_clk) begin
      if (!rstn) begin
         state_q      <= IDLE;
         prev_q       <= '0;
         cnt_q        <= '0;
         seen_q       <= 1'b0;
         locked       <= 1'b0;
         direction    <= 1'b1;
         period       <= '0;
         error_count  <= '0;
         peak_pulse   <= 1'b0;
         trough_pulse <= 1'b0;
         period_valid <= 1'b0;
         error_pulse  <= 1'b0;
      end else begin
         state_q      <= state_d;
         prev_q       <= prev_d;
         cnt_q        <= cnt_d;
         seen_q       <= seen_d;
         locked       <= locked_d;
         direction    <= dir_d;
         period       <= period_d;
         error_count  <= ecnt_d;
         peak_pulse   <= peak_d;
         trough_pulse <= trough_d;
         period_valid <= pv_d;
         error_pulse  <= err_d;
      end
   end

endmodule

// File: tb/tb_triangle_wave_checker.sv
// Bench for triangle_wave_checker: vector table, directed ramps,
// and randomized streams against an arithmetic reference model.
module tb_triangle_wave_checker;

   localparam int MAX = 4095;

   logic        ref_clk = 1'b0;
   logic        rstn;
   logic        locked, direction, peak_pulse, trough_pulse;
   logic [15:0] period;
   logic        period_valid, error_pulse;
   logic [15:0] error_count;
   logic        locked4, direction4, peak4, trough4;
   logic [15:0] period4;
   logic        pv4, err4;
   logic [3:0]  ecnt4;

   triangle_wave_checker_if #(.DATA_WIDTH(12)) sif ();

   triangle_wave_checker dut (
      .ref_clk      (ref_clk),
      .rstn         (rstn),
      .stream       (sif.slave),
      .locked       (locked),
      .direction    (direction),
      .peak_pulse   (peak_pulse),
      .trough_pulse (trough_pulse),
      .period       (period),
      .period_valid (period_valid),
      .error_pulse  (error_pulse),
      .error_count  (error_count)
   );

   triangle_wave_checker #(.ERR_CNT_WIDTH(4)) dut4 (
      .ref_clk      (ref_clk),
      .rstn         (rstn),
      .stream       (sif.slave),
      .locked       (locked4),
      .direction    (direction4),
      .peak_pulse   (peak4),
      .trough_pulse (trough4),
      .period       (period4),
      .period_valid (pv4),
      .error_pulse  (err4),
      .error_count  (ecnt4)
   );

   always #5 ref_clk = ~ref_clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference model: slope is +1/-1 while tracking, 0 while acquiring
   bit m_started, m_seen, m_locked, m_dir;
   bit m_peak, m_trough, m_pv, m_err;
   int m_prev, m_slope, m_cnt, m_period, m_errcnt;

   function automatic int sat16(input int x);
      return (x > 65535) ? 65535 : x;
   endfunction

   function automatic void model_reset();
      m_started = 0; m_seen = 0; m_locked = 0; m_dir = 1;
      m_peak = 0; m_trough = 0; m_pv = 0; m_err = 0;
      m_prev = 0; m_slope = 0; m_cnt = 0; m_period = 0; m_errcnt = 0;
   endfunction

   function automatic void model_step(input bit v, input int s);
      int d;
      m_peak = 0; m_trough = 0; m_pv = 0; m_err = 0;
      if (!v) return;
      if (!m_started) begin
         m_started = 1;
         m_prev = s;
         return;
      end
      d = s - m_prev;
      if (m_slope == 0) begin
         if (d == 1 || d == -1) begin
            m_slope  = d;
            m_peak   = (d == -1 && m_prev == MAX);
            m_trough = (d == 1 && m_prev == 0);
         end
      end else if (d == m_slope) begin
         m_cnt = sat16(m_cnt + 1);
      end else if (d == -m_slope && (m_prev == MAX || m_prev == 0)) begin
         if (m_slope == 1) begin
            m_peak = 1;
            m_cnt = sat16(m_cnt + 1);
         end else begin
            m_trough = 1;
            if (m_seen) begin
               m_period = sat16(m_cnt + 1);
               m_pv = 1;
               m_locked = 1;
            end
            m_seen = 1;
            m_cnt = 0;
         end
         m_slope = -m_slope;
      end else begin
         m_err = 1;
         m_errcnt = sat16(m_errcnt + 1);
         m_locked = 0;
         m_seen = 0;
         m_slope = 0;
      end
      if (m_slope == 1) m_dir = 1;
      else if (m_slope == -1) m_dir = 0;
      m_prev = s;
   endfunction

   task automatic compare_model();
      logic [63:0] a, e;
      int e4;
      a = {26'd0, locked, direction, peak_pulse, trough_pulse,
           period_valid, error_pulse, period, error_count};
      e = {26'd0, m_locked, m_dir, m_peak, m_trough,
           m_pv, m_err, 16'(m_period), 16'(m_errcnt)};
      check("model", a, e);
      e4 = (m_errcnt > 15) ? 15 : m_errcnt;
      check("model_w4", {59'd0, err4, ecnt4}, {59'd0, m_err, 4'(e4)});
   endtask

   task automatic tick(input bit r, input bit v, input int s);
      rstn = r;
      sif.sample_valid = v;
      sif.sample = s[11:0];
      @(posedge ref_clk);
      if (!r) model_reset();
      else model_step(v, s);
      #1;
      compare_model();
   endtask

   // Triangle walker plus optional idle cycle before every 3rd sample
   int tri_v, tri_d, gap_ctr;

   function automatic void adv();
      if (tri_d == 1 && tri_v == MAX) tri_d = -1;
      else if (tri_d == -1 && tri_v == 0) tri_d = 1;
      tri_v += tri_d;
   endfunction

   task automatic feed(input int s, input bit gaps);
      if (gaps) begin
         gap_ctr++;
         if (gap_ctr % 3 == 0) tick(1, 0, int'($urandom_range(0, MAX)));
      end
      tick(1, 1, s);
   endtask

   task automatic do_reset();
      tick(0, 0, 0);
      tick(0, 0, 0);
   endtask

   typedef struct {
      bit          v;
      int          s;
      bit          err;
      bit          peak;
      bit          trough;
      bit          dir;
      int          ecnt;
   } vec_t;

   vec_t tbl[19];

   initial begin
      int tr, pvs, n;
      bit saw_peak;

      tbl[0]  = '{1, 'h3FE, 0, 0, 0, 1, 0};
      tbl[1]  = '{1, 'h3FF, 0, 0, 0, 1, 0};
      tbl[2]  = '{1, 'h400, 0, 0, 0, 1, 0};
      tbl[3]  = '{1, 'h400, 1, 0, 0, 1, 1};
      tbl[4]  = '{1, 'h401, 0, 0, 0, 1, 1};
      tbl[5]  = '{0, 'h000, 0, 0, 0, 1, 1};
      tbl[6]  = '{1, 'h402, 0, 0, 0, 1, 1};
      tbl[7]  = '{1, 'hFFF, 1, 0, 0, 1, 2};
      tbl[8]  = '{1, 'h000, 0, 0, 0, 1, 2};
      tbl[9]  = '{1, 'h001, 0, 0, 1, 1, 2};
      tbl[10] = '{1, 'h000, 1, 0, 0, 1, 3};
      tbl[11] = '{1, 'hFFE, 0, 0, 0, 1, 3};
      tbl[12] = '{1, 'hFFF, 0, 0, 0, 1, 3};
      tbl[13] = '{1, 'h000, 1, 0, 0, 1, 4};
      tbl[14] = '{1, 'hFFF, 0, 0, 0, 1, 4};
      tbl[15] = '{1, 'hFFE, 0, 1, 0, 0, 4};
      tbl[16] = '{1, 'hFFD, 0, 0, 0, 0, 4};
      tbl[17] = '{1, 'hFFE, 1, 0, 0, 0, 5};
      tbl[18] = '{0, 'h123, 0, 0, 0, 0, 5};

      rstn = 0;
      sif.sample_valid = 0;
      sif.sample = '0;
      gap_ctr = 0;
      model_reset();

      do_reset();
      check("rst_locked", 64'(locked), 64'd0);
      check("rst_dir", 64'(direction), 64'd1);
      check("rst_period", 64'(period), 64'd0);
      check("rst_ecnt", 64'(error_count), 64'd0);

      // Clean ramp from zero: three 0->1 transitions, last one measures
      tri_v = 0; tri_d = 1;
      saw_peak = 0;
      for (int i = 0; i < 16382; i++) begin
         feed(tri_v, 0);
         if (i == 4096) check("peak_after_ffe", 64'(peak_pulse), 64'd1);
         adv();
      end
      check("ideal_period", 64'(period), 64'd8190);
      check("ideal_pv", 64'(period_valid), 64'd1);
      check("ideal_locked", 64'(locked), 64'd1);
      check("ideal_ecnt", 64'(error_count), 64'd0);

      // Same ramp continued with idle cycles interleaved
      pvs = 0;
      for (int i = 0; i < 8190; i++) begin
         feed(tri_v, 1);
         if (period_valid) pvs++;
         adv();
      end
      check("gap_pv_count", 64'(pvs), 64'd1);
      check("gap_period", 64'(period), 64'd8190);
      check("gap_ecnt", 64'(error_count), 64'd0);
      check("gap_locked", 64'(locked), 64'd1);

      // Mid-ramp start at 0x123
      do_reset();
      tri_v = 'h123; tri_d = 1;
      feed(tri_v, 0); adv();
      feed(tri_v, 0); adv();
      check("mid_dir", 64'(direction), 64'd1);
      check("mid_noerr", 64'(error_pulse), 64'd0);
      tr = 0;
      for (int i = 0; i < 20000 && tr < 2; i++) begin
         feed(tri_v, 0);
         if (trough_pulse) begin
            tr++;
            if (tr == 1) check("mid_unlocked1", 64'(locked), 64'd0);
         end
         adv();
      end
      check("mid_troughs", 64'(tr), 64'd2);
      check("mid_locked", 64'(locked), 64'd1);
      check("mid_period", 64'(period), 64'd8190);

      // Glitch 0x800 -> 0x805 while locked
      n = 0;
      while (tri_v != 'h800 && n < 9000) begin
         feed(tri_v, 0); adv(); n++;
      end
      feed('h805, 0);
      check("glitch_err", 64'(error_pulse), 64'd1);
      check("glitch_ecnt", 64'(error_count), 64'd1);
      check("glitch_unlock", 64'(locked), 64'd0);
      tri_v = 'h806;
      feed(tri_v, 0); adv();
      check("resume_noerr", 64'(error_pulse), 64'd0);
      check("resume_dir", 64'(direction), 64'd1);
      tr = 0;
      for (int i = 0; i < 20000 && tr < 2; i++) begin
         feed(tri_v, 0);
         if (trough_pulse) begin
            tr++;
            if (tr == 1) check("relock_not_yet", 64'(locked), 64'd0);
         end
         adv();
      end
      check("relock_troughs", 64'(tr), 64'd2);
      check("relock_locked", 64'(locked), 64'd1);

      // Vector table: repeats, wraps, turnarounds in acquisition
      do_reset();
      foreach (tbl[i]) begin
         tick(1, tbl[i].v, tbl[i].s);
         check($sformatf("vec%0d_err", i), 64'(error_pulse), 64'(tbl[i].err));
         check($sformatf("vec%0d_peak", i), 64'(peak_pulse), 64'(tbl[i].peak));
         check($sformatf("vec%0d_trough", i), 64'(trough_pulse),
               64'(tbl[i].trough));
         check($sformatf("vec%0d_dir", i), 64'(direction), 64'(tbl[i].dir));
         check($sformatf("vec%0d_ecnt", i), 64'(error_count),
               64'(tbl[i].ecnt));
      end

      // Twenty errors: narrow counter saturates, pulse keeps firing
      do_reset();
      tick(1, 1, 'h10);
      for (int k = 0; k < 20; k++) begin
         tick(1, 1, 'h11 + k);
         tick(1, 1, 'h11 + k);
         check($sformatf("sat_pulse%0d", k), 64'(err4), 64'd1);
      end
      check("sat_ecnt4", 64'(ecnt4), 64'd15);
      check("sat_ecnt16", 64'(error_count), 64'd20);

      // Randomized ramps with glitches, gaps and occasional resets
      do_reset();
      tri_v = int'($urandom_range(0, MAX));
      tri_d = ($urandom_range(0, 1) == 1) ? 1 : -1;
      for (int i = 0; i < 4000; i++) begin
         n = int'($urandom_range(0, 999));
         if (n < 3) begin
            tick(0, 0, 0);
         end else if (n < 250) begin
            tick(1, 0, int'($urandom_range(0, MAX)));
         end else if (n < 270) begin
            tick(1, 1, int'($urandom_range(0, MAX)));
         end else if (n < 275) begin
            tri_v = ($urandom_range(0, 1) == 1) ? MAX - 3 : 3;
            tick(1, 1, tri_v);
            adv();
         end else begin
            tick(1, 1, tri_v);
            adv();
         end
      end

      // Reset in the middle of a period
      for (int i = 0; i < 50; i++) begin
         feed(tri_v, 0); adv();
      end
      tick(0, 1, tri_v);
      check("mrst_locked", 64'(locked), 64'd0);
      check("mrst_dir", 64'(direction), 64'd1);
      check("mrst_period", 64'(period), 64'd0);
      check("mrst_ecnt", 64'(error_count), 64'd0);
      check("mrst_pulses", {60'd0, peak_pulse, trough_pulse, period_valid,
                            error_pulse}, 64'd0);

      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errors);
      $finish;
   end

endmodule
